// File: rtl/data_mem_controller.sv
// Round-robin LSU data-memory responder: arbitrates per-port load/store requests onto one memory.
// Each grant runs MEM_LATENCY access cycles, a one-cycle ready pulse, then one dead cycle.
module data_mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               busy
);

  localparam int PW    = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, RELEASE} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [PW-1:0]                  port_q, port_d;
  logic [PW-1:0]                  last_q, last_d;
  logic                           is_rd_q, is_rd_d;
  logic [ADDR_BITS-1:0]           addr_q, addr_d;
  logic [DATA_BITS-1:0]           wdata_q, wdata_d;
  logic [NUM_CONSUMERS-1:0]       rd_rdy_q, rd_rdy_d;
  logic [NUM_CONSUMERS-1:0]       wr_rdy_q, wr_rdy_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [DATA_BITS-1:0]           mem_q [DEPTH];
  logic                           mem_we;
  logic                           cand_found;
  logic [PW-1:0]                  gnt_port;

  // Rotating-priority search starting just after the last served port.
  always_comb begin
    cand_found = 1'b0;
    gnt_port   = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      int idx;
      idx = (int'(last_q) + 1 + i) % NUM_CONSUMERS;
      if (!cand_found && (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
        cand_found = 1'b1;
        gnt_port   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    last_d    = last_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_rdy_d  = '0;
    wr_rdy_d  = '0;
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;
    case (state_q)
      // The dead cycle also arbitrates: the served consumer's valid has already dropped.
      IDLE, RELEASE: begin
        state_d = IDLE;
        if (cand_found) begin
          state_d = ACCESS;
          port_d  = gnt_port;
          is_rd_d = consumer_read_valid[gnt_port];
          addr_d  = consumer_read_valid[gnt_port]
                    ? consumer_read_address[int'(gnt_port)*ADDR_BITS +: ADDR_BITS]
                    : consumer_write_address[int'(gnt_port)*ADDR_BITS +: ADDR_BITS];
          wdata_d = consumer_write_data[int'(gnt_port)*DATA_BITS +: DATA_BITS];
          cnt_d   = CW'(MEM_LATENCY - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESPOND;
          last_d  = port_q;
          if (is_rd_q) begin
            rd_rdy_d[port_q] = 1'b1;
            rd_data_d[int'(port_q)*DATA_BITS +: DATA_BITS] = mem_q[addr_q];
          end else begin
            wr_rdy_d[port_q] = 1'b1;
            mem_we           = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: state_d = RELEASE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      port_q    <= '0;
      last_q    <= PW'(NUM_CONSUMERS - 1);
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_rdy_q  <= '0;
      wr_rdy_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      last_q    <= last_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_rdy_q  <= rd_rdy_d;
      wr_rdy_q  <= wr_rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign consumer_read_ready  = rd_rdy_q;
  assign consumer_write_ready = wr_rdy_q;
  assign consumer_read_data   = rd_data_q;
  assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller with a queue scoreboard checked by a negedge monitor.
module tb_data_mem_controller #(parameter int LAT = 2);
  localparam int NC = 4, AB = 8, DB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          rd_vld_a [NC];
  logic [AB-1:0] rd_addr_a[NC];
  logic          wr_vld_a [NC];
  logic [AB-1:0] wr_addr_a[NC];
  logic [DB-1:0] wr_data_a[NC];

  logic [NC-1:0]    rd_vld, wr_vld, rd_rdy, wr_rdy;
  logic [NC*AB-1:0] rd_addr, wr_addr;
  logic [NC*DB-1:0] wr_data, rd_data;
  logic             busy;

  always_comb begin
    rd_vld = '0; wr_vld = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    for (int p = 0; p < NC; p++) begin
      rd_vld[p]            = rd_vld_a[p];
      wr_vld[p]            = wr_vld_a[p];
      rd_addr[p*AB +: AB]  = rd_addr_a[p];
      wr_addr[p*AB +: AB]  = wr_addr_a[p];
      wr_data[p*DB +: DB]  = wr_data_a[p];
    end
  end

  data_mem_controller #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rd_vld), .consumer_read_address(rd_addr),
    .consumer_read_ready(rd_rdy), .consumer_read_data(rd_data),
    .consumer_write_valid(wr_vld), .consumer_write_address(wr_addr),
    .consumer_write_data(wr_data), .consumer_write_ready(wr_rdy),
    .busy(busy)
  );

  typedef struct {bit is_rd; int port; logic [DB-1:0] data;} exp_t;
  exp_t sb[$];
  int   rdy_cyc[$];
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, busy_total = 0, issue_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy === 1'b1) busy_total <= busy_total + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && (|{rd_rdy, wr_rdy})) begin
      check("ready_onehot", 64'($countones({rd_rdy, wr_rdy})), 64'd1);
      for (int p = 0; p < NC; p++) begin
        if (rd_rdy[p] || wr_rdy[p]) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_ready: port %0d rd=%0b wr=%0b with empty scoreboard", p, rd_rdy[p], wr_rdy[p]);
          end else begin
            e = sb.pop_front();
            check("sb_port", 64'(p), 64'(e.port));
            check("sb_op_is_read", 64'(rd_rdy[p]), 64'(e.is_rd));
            if (e.is_rd) check("sb_read_data", 64'(rd_data[p*DB +: DB]), 64'(e.data));
          end
          rdy_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic exp_t mk(bit is_rd, int port, logic [DB-1:0] data);
    exp_t e;
    e.is_rd = is_rd; e.port = port; e.data = data;
    return e;
  endfunction

  // Consumer model: hold valids until the matching ready is seen, drop them on the next edge.
  task automatic req(int p, bit rd, bit wr, logic [AB-1:0] addr, logic [DB-1:0] wd);
    bit rp = rd, wp = wr;
    int budget = 0;
    @(posedge clk); #1;
    rd_addr_a[p] = addr; wr_addr_a[p] = addr; wr_data_a[p] = wd;
    rd_vld_a[p] = rd; wr_vld_a[p] = wr;
    issue_cyc = cyc;
    while ((rp || wp) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (rd_rdy[p]) rp = 0;
      if (wr_rdy[p]) wp = 0;
      @(posedge clk); #1;
      rd_vld_a[p] = rp; wr_vld_a[p] = wp;
    end
    if (rp || wp) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: port %0d still pending rd=%0b wr=%0b", p, rp, wp);
      rd_vld_a[p] = 0; wr_vld_a[p] = 0;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_read_ready"}, 64'(rd_rdy), 64'd0);
    check({tag, "_write_ready"}, 64'(wr_rdy), 64'd0);
    check({tag, "_read_data"}, 64'(rd_data), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, n0;
    for (int p = 0; p < NC; p++) begin
      rd_vld_a[p] = 0; wr_vld_a[p] = 0; rd_addr_a[p] = 0; wr_addr_a[p] = 0; wr_data_a[p] = 0;
    end
    reset = 1'b1;
    #2;
    check_reset_outputs("reset");
    #10 reset = 1'b0;

    // Single read after reset: timing, one-cycle pulse, busy length.
    b0 = busy_total; n0 = rdy_cyc.size();
    sb.push_back(mk(1, 0, 8'h00));
    req(0, 1, 0, 8'h10, 8'h00);
    repeat (3) @(negedge clk);
    check("t1_ready_latency", 64'(rdy_cyc[n0] - issue_cyc), 64'(LAT + 1));
    check("t1_busy_cycles", 64'(busy_total - b0), 64'(LAT + 2));
    check("t1_read_data0", 64'(rd_data[0 +: DB]), 64'h00);

    // Store then load through different ports; load data is held afterwards.
    sb.push_back(mk(0, 1, 8'h00));
    req(1, 0, 1, 8'h20, 8'hA5);
    sb.push_back(mk(1, 2, 8'hA5));
    req(2, 1, 0, 8'h20, 8'h00);
    repeat (3) @(negedge clk);
    check("t2_read_data_held", 64'(rd_data[2*DB +: DB]), 64'hA5);

    // Fresh reset, preload, then all four ports read at once.
    @(negedge clk); reset = 1'b1; #1 check_reset_outputs("reset2");
    @(negedge clk); reset = 1'b0;
    for (int p = 0; p < NC; p++) begin
      sb.push_back(mk(0, p, 8'h00));
      req(p, 0, 1, 8'h30 + 8'(p), 8'h40 + 8'(p));
    end
    n0 = rdy_cyc.size();
    for (int p = 0; p < NC; p++) sb.push_back(mk(1, p, 8'h40 + 8'(p)));
    fork
      req(0, 1, 0, 8'h30, 8'h00);
      req(1, 1, 0, 8'h31, 8'h00);
      req(2, 1, 0, 8'h32, 8'h00);
      req(3, 1, 0, 8'h33, 8'h00);
    join
    repeat (3) @(negedge clk);
    check("t3_ready_count", 64'(rdy_cyc.size() - n0), 64'd4);
    for (int k = 1; k < 4; k++)
      if (rdy_cyc.size() >= n0 + 4)
        check("t3_grant_spacing", 64'(rdy_cyc[n0 + k] - rdy_cyc[n0 + k - 1]), 64'(LAT + 2));
    // Next round after port 3 wraps to port 0 ahead of port 2.
    sb.push_back(mk(1, 0, 8'h40));
    sb.push_back(mk(1, 2, 8'h42));
    fork
      req(2, 1, 0, 8'h32, 8'h00);
      req(0, 1, 0, 8'h30, 8'h00);
    join

    // Simultaneous read and write on port 3: read first sees old data.
    sb.push_back(mk(1, 3, 8'h00));
    sb.push_back(mk(0, 3, 8'h00));
    req(3, 1, 1, 8'h05, 8'h3C);
    sb.push_back(mk(1, 3, 8'h3C));
    req(3, 1, 0, 8'h05, 8'h00);

    // Reset during ACCESS of a write aborts it.
    @(posedge clk); #1;
    wr_addr_a[0] = 8'h07; wr_data_a[0] = 8'hFF; wr_vld_a[0] = 1'b1;
    @(posedge clk); #3;
    check("t5_busy_in_access", 64'(busy), 64'd1);
    reset = 1'b1;
    #1 check_reset_outputs("t5_async");
    wr_vld_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    sb.push_back(mk(1, 0, 8'h00));
    sb.push_back(mk(1, 3, 8'h00));
    fork
      req(3, 1, 0, 8'h07, 8'h00);
      req(0, 1, 0, 8'h30, 8'h00);
    join

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_controller.md
# data_mem_controller

Responder side of the LSU data-memory valid/ready protocol. It accepts load and store requests from NUM_CONSUMERS per-thread load-store units and arbitrates them round-robin onto a single internal data memory of 2^ADDR_BITS words. Each accepted request completes after a fixed MEM_LATENCY, followed by a one-cycle ready pulse back to the requesting unit. It sits between the cores' LSUs and data storage, one instance per GPU.

## Interface
- NUM_CONSUMERS, 4: number of LSU request ports (≥1).
- ADDR_BITS, 8: address width; memory depth is 2^ADDR_BITS.
- DATA_BITS, 8: data word width.
- MEM_LATENCY, 2: cycles spent in ACCESS per transaction (≥1).
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and memory.
- consumer_read_valid  in  NUM_CONSUMERS  per-port load request, held until ready seen.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  flattened; port i at [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  one-cycle completion pulse per port.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  registered load data, held until the next load response to that port.
- consumer_write_valid  in  NUM_CONSUMERS  per-port store request.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  store address.
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  store data.
- consumer_write_ready  out  NUM_CONSUMERS  one-cycle store completion pulse.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ACCESS, RESPOND, RELEASE.
- IDLE: candidates are ports with read_valid or write_valid high. Search starts at (last_grant+1) mod NUM_CONSUMERS and takes the first candidate. Latch the port index, op (read has priority if both valids are high on that port), address, and write data. Go to ACCESS with counter = MEM_LATENCY-1. No candidate: stay in IDLE.
- ACCESS: if counter==0 go to RESPOND, else decrement. On the RESPOND transition:
  - read: load consumer_read_data[port] from mem[addr] and set read_ready[port]=1.
  - write: set mem[addr]=latched data and write_ready[port]=1.
  - Update last_grant to the port.
- RESPOND: ready high for exactly this cycle. Next edge: clear ready, go to RELEASE.
- RELEASE: one dead cycle so the consumer's valid deassertion (registered on the edge it sees ready) is visible. Then IDLE. This guarantees a request is never served twice.
- Requests are latched at grant. Input changes or valid withdrawal after grant do not affect the transaction; it completes and pulses ready regardless.
- last_grant resets to NUM_CONSUMERS-1, so port 0 has first priority after reset.
- Reset values: all ready bits 0, all consumer_read_data 0, busy 0, state IDLE, counter 0, every memory word 0.

## Timing
- Valid sampled high at grant edge E0. Ready rises at E0+MEM_LATENCY and falls at E0+MEM_LATENCY+1. Next grant can occur at E0+MEM_LATENCY+2.
- Throughput: one transaction per MEM_LATENCY+2 cycles, shared across all ports.
- A read issued in the cycle right after a write to the same address returns the new data, because the write is committed before RELEASE.
- At most one ready bit (read or write, any port) is high in any cycle.
- Asynchronous reset mid-transaction aborts it immediately: no ready pulse, no memory write. After release, arbitration restarts at port 0.

## Test plan
- After reset, port 0 reads address 0x10 with MEM_LATENCY=2 -> read_ready[0] high exactly one cycle, 2 edges after grant; read_data[0]=0x00; busy high for 4 cycles.
- Port 1 writes 0xA5 to 0x20, then port 2 reads 0x20 -> write_ready[1] pulse, then read_data[2]=0xA5, held after ready falls.
- Ports 0–3 all assert read_valid in the same cycle and hold until their ready -> grants in order 0,1,2,3, spaced 4 cycles apart. Next round after port 3 restarts at 0. No port served twice per request.
- Port 3 asserts read (0x05) and write (0x05, 0x3C) at the same time -> read served first and returns the old value 0x00; write served on a later grant; a subsequent read returns 0x3C.
- Reset asserted mid-ACCESS of a write of 0xFF to 0x07 -> no ready pulse, outputs 0 asynchronously, later read of 0x07 returns 0x00.
- MEM_LATENCY=1 and MEM_LATENCY=5 builds -> ready edge at E0+1 and E0+5, dead cycle preserved, data correct.
